instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Pipeline IF stage of the MIPS datapath: owns the program counter, the instruction memory and the IF/ID pipeline register. It produces the instruction and PC+4 consumed by the ID stage, and obeys the stall signals (PCWrite, if_id_write) that ID's hazard detector generates. It also takes branch/jump redirects and exposes a load handshake through which the debug unit writes the program before execution.

## Interface
- PC_BITS, 32, PC width (byte address)
- INSTRUCTION_BITS, 32, instruction word width
- IMEM_ADDR_BITS, 8, word-address width; memory depth = 2**IMEM_ADDR_BITS words
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_enable  in  1  debug run/step enable; low freezes all state except the loader write
- i_start  in  1  leave LOAD and begin execution
- i_PCWrite  in  1  from hazard detector; 0 holds PC
- i_if_id_write  in  1  from hazard detector; 0 holds IF/ID
- i_branch_taken  in  1  taken branch resolved in EX
- i_branch_address  in  PC_BITS  branch target
- i_jump_taken  in  1  jump decoded in ID
- i_jump_address  in  PC_BITS  jump target
- i_load_valid  in  1  loader word valid
- i_load_address  in  IMEM_ADDR_BITS  word address
- i_load_data  in  INSTRUCTION_BITS  word
- o_load_ready  out  1  loader may write
- o_instruction  out  INSTRUCTION_BITS  IF/ID instruction
- o_PCNext  out  PC_BITS  IF/ID PC+4
- o_PC  out  PC_BITS  current PC (debug)
- o_halt  out  1  HALT fetched, stage frozen

## Operation
- FSM: LOAD, RUN, HALTED. Reset → LOAD.
- LOAD: o_load_ready=1; i_load_valid writes mem[i_load_address]<=i_load_data. i_start → RUN next edge, PC=0. Write and i_start in the same cycle: write completes, then RUN.
- RUN/HALTED: o_load_ready=0; i_load_valid ignored.
- Memory: synchronous write, combinational read at word index PC[IMEM_ADDR_BITS+1:2]. PC beyond depth wraps modulo depth. Contents not reset.
- Next PC (RUN, i_enable=1), priority: i_branch_taken → i_branch_address; else i_jump_taken → i_jump_address; else PC+4 (wraps mod 2**PC_BITS).
- PC updates when i_PCWrite=1 or a redirect is taken; a redirect overrides a stall.
- IF/ID loads {mem[PC], PC+4} when i_if_id_write=1.
- Flush: a taken redirect loads IF/ID with instruction 0 (NOP), PCNext 0, regardless of i_if_id_write.
- HALT word = all ones. When it is loaded into IF/ID: state → HALTED, o_halt=1. PC frozen from then on. Each later enabled cycle loads NOP into IF/ID (pipeline drain). HALTED exits only via rst.

## Timing
- Reset values: PC=0, o_instruction=0, o_PCNext=0, o_halt=0, o_load_ready=1, state LOAD.
- Fetch latency: 1 cycle. Word at PC appears on o_instruction after the next enabled edge.
- o_PC, o_load_ready and o_halt are decoded from registers; no combinational input→output path.
- i_enable=0: PC, IF/ID and FSM hold. The loader still writes in LOAD.
- Branch and jump in the same cycle: branch wins (older instruction).
- Reset asserted mid-RUN: immediate return to reset values. Memory keeps its contents.

## Configuration
- IF_DELAY_SLOT_EN defined: no flush. The instruction after a taken branch/jump enters IF/ID normally, subject to i_if_id_write (delay-slot semantics). A redirect still overrides the PC stall.
- Undefined (default): flush as described in Operation.

## Test plan
- Load mem[0..2]=0x20010005,0x20020007,0xFFFFFFFF; i_start; i_enable=1 → o_instruction sequence 0x20010005 (PCNext 4), 0x20020007 (PCNext 8), 0xFFFFFFFF with o_halt=1; then 0x00000000 with o_PC frozen at 12.
- Stall: i_PCWrite=0, i_if_id_write=0 for 2 cycles at PC=8 → o_PC=8, o_instruction unchanged; release → PC=12.
- Branch at PC=8 with i_branch_taken=1, target 0x40, and i_jump_taken=1 same cycle → o_PC=0x40, o_instruction=0 (flush). With IF_DELAY_SLOT_EN → o_instruction=mem[2].
- Loader gating: i_load_valid=1 in RUN with address 0, data 0x12345678 → mem[0] unchanged, o_load_ready=0.
- rst pulse mid-RUN at PC=0x10 → o_PC=0, o_instruction=0, o_load_ready=1 asynchronously; after i_start, fetch of mem[0] returns the preloaded word.
- i_enable=0 for 3 cycles in RUN → all outputs constant; wrap: PC=4*(2**IMEM_ADDR_BITS) fetches mem[0].

Source files
------------

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, instruction memory with debug loader, and IF/ID register.
// Define IF_DELAY_SLOT_EN for delay-slot semantics (no flush on taken redirect).
module instruction_fetch #(
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int IMEM_ADDR_BITS   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_start,
  input  logic                        i_PCWrite,
  input  logic                        i_if_id_write,
  input  logic                        i_branch_taken,
  input  logic [PC_BITS-1:0]          i_branch_address,
  input  logic                        i_jump_taken,
  input  logic [PC_BITS-1:0]          i_jump_address,
  input  logic                        i_load_valid,
  input  logic [IMEM_ADDR_BITS-1:0]   i_load_address,
  input  logic [INSTRUCTION_BITS-1:0] i_load_data,
  output logic                        o_load_ready,
  output logic [INSTRUCTION_BITS-1:0] o_instruction,
  output logic [PC_BITS-1:0]          o_PCNext,
  output logic [PC_BITS-1:0]          o_PC,
  output logic                        o_halt
);

  // state      | meaning
  // ST_LOAD    | loader owns memory, execution not started
  // ST_RUN     | fetching, PC advancing
  // ST_HALTED  | HALT reached IF/ID, PC frozen, IF/ID drains NOPs
  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALTED} state_t;

  localparam int IMEM_DEPTH = 2 ** IMEM_ADDR_BITS;
  localparam logic [INSTRUCTION_BITS-1:0] HALT_WORD = '1;

  state_t state, state_next;

  logic [INSTRUCTION_BITS-1:0] mem [IMEM_DEPTH];
  logic [PC_BITS-1:0]          pc, pc_plus4, pc_next;
  logic [IMEM_ADDR_BITS-1:0]   fetch_index;
  logic [INSTRUCTION_BITS-1:0] fetch_word;
  logic                        redirect;
  logic                        run_cycle;
  logic                        fetch_load;
  logic                        halt_fetched;

  assign fetch_index = pc[IMEM_ADDR_BITS+1:2];
  assign fetch_word  = mem[fetch_index];
  assign pc_plus4    = pc + PC_BITS'(4);
  assign redirect    = i_branch_taken | i_jump_taken;
  assign run_cycle   = (state == ST_RUN) && i_enable;

  // Branch resolves in EX, so it belongs to an older instruction than the jump
  always_comb begin
    pc_next = pc_plus4;
    if (i_branch_taken)
      pc_next = i_branch_address;
    else if (i_jump_taken)
      pc_next = i_jump_address;
  end

  always_comb begin
`ifdef IF_DELAY_SLOT_EN
    fetch_load = i_if_id_write;
`else
    fetch_load = i_if_id_write && !redirect;
`endif
    halt_fetched = run_cycle && fetch_load && (fetch_word == HALT_WORD);
  end

  // Loader writes ignore i_enable so the program can be written while frozen
  always_ff @(posedge clk) begin
    if ((state == ST_LOAD) && i_load_valid)
      mem[i_load_address] <= i_load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_LOAD;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:   if (i_enable && i_start) state_next = ST_RUN;
      ST_RUN:    if (halt_fetched) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    o_load_ready = (state == ST_LOAD);
    o_halt       = (state == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= '0;
      o_instruction <= '0;
      o_PCNext      <= '0;
    end else if (i_enable) begin
      case (state)
        ST_LOAD: begin
          if (i_start)
            pc <= '0;
        end
        ST_RUN: begin
          if (i_PCWrite || redirect)
            pc <= pc_next;
          if (fetch_load) begin
            o_instruction <= fetch_word;
            o_PCNext      <= pc_plus4;
          end
`ifndef IF_DELAY_SLOT_EN
          else if (redirect) begin
            o_instruction <= '0;
            o_PCNext      <= '0;
          end
`endif
        end
        ST_HALTED: begin
          o_instruction <= '0;
          o_PCNext      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_PC = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load, fetch, stall, redirect, halt, reset, wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_start, i_PCWrite, i_if_id_write;
  logic        i_branch_taken, i_jump_taken, i_load_valid;
  logic [31:0] i_branch_address, i_jump_address, i_load_data;
  logic [7:0]  i_load_address;
  logic        o_load_ready, o_halt;
  logic [31:0] o_instruction, o_PCNext, o_PC;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_instr, exp_pcnext;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .i_enable         (i_enable),
    .i_start          (i_start),
    .i_PCWrite        (i_PCWrite),
    .i_if_id_write    (i_if_id_write),
    .i_branch_taken   (i_branch_taken),
    .i_branch_address (i_branch_address),
    .i_jump_taken     (i_jump_taken),
    .i_jump_address   (i_jump_address),
    .i_load_valid     (i_load_valid),
    .i_load_address   (i_load_address),
    .i_load_data      (i_load_data),
    .o_load_ready     (o_load_ready),
    .o_instruction    (o_instruction),
    .o_PCNext         (o_PCNext),
    .o_PC             (o_PC),
    .o_halt           (o_halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    i_load_valid   = 1'b1;
    i_load_address = addr;
    i_load_data    = data;
    step();
    i_load_valid   = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    i_jump_taken   = 1'b1;
    i_jump_address = addr;
    step();
    i_jump_taken   = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pcn);
    check({tag, "_instr"}, o_instruction, instr);
    check({tag, "_pcnext"}, o_PCNext, pcn);
  endtask

  initial begin
    rst = 1'b1;
    i_enable = 1'b0; i_start = 1'b0; i_PCWrite = 1'b1; i_if_id_write = 1'b1;
    i_branch_taken = 1'b0; i_branch_address = '0;
    i_jump_taken = 1'b0; i_jump_address = '0;
    i_load_valid = 1'b0; i_load_address = '0; i_load_data = '0;
    repeat (2) step();

    check("rst_pc", o_PC, 32'h0);
    check_ifid("rst", 32'h0, 32'h0);
    check("rst_ready", {31'b0, o_load_ready}, 32'h1);
    check("rst_halt", {31'b0, o_halt}, 32'h0);
    rst = 1'b0;

    // Program run to HALT, with a stall at PC=8
    i_enable = 1'b1;
    load_word(8'd0, 32'h20010005);
    load_word(8'd1, 32'h20020007);
    load_word(8'd2, 32'hFFFFFFFF);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("start_pc", o_PC, 32'h0);
    check("start_ready", {31'b0, o_load_ready}, 32'h0);

    step();
    check_ifid("f0", 32'h20010005, 32'h4);
    check("f0_pc", o_PC, 32'h4);
    step();
    check_ifid("f1", 32'h20020007, 32'h8);
    check("f1_pc", o_PC, 32'h8);

    i_PCWrite = 1'b0; i_if_id_write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_pc", o_PC, 32'h8);
      check("stall_instr", o_instruction, 32'h20020007);
    end
    i_PCWrite = 1'b1; i_if_id_write = 1'b1;

    step();
    check_ifid("halt", 32'hFFFFFFFF, 32'hC);
    check("halt_pc", o_PC, 32'hC);
    check("halt_flag", {31'b0, o_halt}, 32'h1);
    step();
    check_ifid("drain", 32'h0, 32'h0);
    check("drain_pc", o_PC, 32'hC);
    check("drain_halt", {31'b0, o_halt}, 32'h1);

    load_word(8'd0, 32'h12345678);
    check("halted_ready", {31'b0, o_load_ready}, 32'h0);

    // Asynchronous reset out of HALTED
    rst = 1'b1;
    #1;
    check("arst1_pc", o_PC, 32'h0);
    check_ifid("arst1", 32'h0, 32'h0);
    check("arst1_ready", {31'b0, o_load_ready}, 32'h1);
    check("arst1_halt", {31'b0, o_halt}, 32'h0);
    step();
    rst = 1'b0;

    // Loader works with i_enable low
    i_enable = 1'b0;
    load_word(8'd2, 32'h20030009);
    load_word(8'd3, 32'h2004000B);
    load_word(8'd4, 32'h2005000D);
    load_word(8'd16, 32'hAAAA0001);
    load_word(8'd255, 32'hBBBB00FF);

    // Final write and start in the same cycle
    i_enable = 1'b1;
    i_start = 1'b1;
    load_word(8'd5, 32'h2006000F);
    i_start = 1'b0;
    check("start2_ready", {31'b0, o_load_ready}, 32'h0);
    check("start2_pc", o_PC, 32'h0);

    step();
    check_ifid("g0", 32'h20010005, 32'h4);
    step();
    check_ifid("g1", 32'h20020007, 32'h8);

    // Branch and jump together at PC=8: branch wins
    i_branch_taken = 1'b1; i_branch_address = 32'h40;
    i_jump_taken = 1'b1; i_jump_address = 32'h80;
    step();
    i_branch_taken = 1'b0; i_jump_taken = 1'b0;
    check("br_pc", o_PC, 32'h40);
`ifdef IF_DELAY_SLOT_EN
    exp_instr = 32'h20030009; exp_pcnext = 32'hC;
`else
    exp_instr = 32'h0; exp_pcnext = 32'h0;
`endif
    check_ifid("br", exp_instr, exp_pcnext);

    step();
    check_ifid("tgt", 32'hAAAA0001, 32'h44);
    check("tgt_pc", o_PC, 32'h44);

    // Jump overrides a full stall
    i_PCWrite = 1'b0; i_if_id_write = 1'b0;
    jump_to(32'h10);
    i_PCWrite = 1'b1; i_if_id_write = 1'b1;
    check("jstall_pc", o_PC, 32'h10);
`ifdef IF_DELAY_SLOT_EN
    exp_instr = 32'hAAAA0001; exp_pcnext = 32'h44;
`else
    exp_instr = 32'h0; exp_pcnext = 32'h0;
`endif
    check_ifid("jstall", exp_instr, exp_pcnext);

    // Frozen for 3 cycles despite redirect and loader activity
    i_enable = 1'b0;
    i_branch_taken = 1'b1; i_branch_address = 32'h80;
    i_load_valid = 1'b1; i_load_address = 8'd0; i_load_data = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      step();
      check("frz_pc", o_PC, 32'h10);
      check_ifid("frz", exp_instr, exp_pcnext);
      check("frz_ready", {31'b0, o_load_ready}, 32'h0);
    end
    i_branch_taken = 1'b0; i_load_valid = 1'b0;

    // Reset mid-RUN at PC=0x10
    rst = 1'b1;
    #1;
    check("arst2_pc", o_PC, 32'h0);
    check_ifid("arst2", 32'h0, 32'h0);
    check("arst2_ready", {31'b0, o_load_ready}, 32'h1);
    step();
    rst = 1'b0;
    i_enable = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    check_ifid("h0", 32'h20010005, 32'h4);

    jump_to(32'h14);
    check("j14_pc", o_PC, 32'h14);
    step();
    check_ifid("m5", 32'h2006000F, 32'h18);

    // Word-index wrap
    jump_to(32'h3FC);
    check("j3fc_pc", o_PC, 32'h3FC);
    step();
    check_ifid("m255", 32'hBBBB00FF, 32'h400);
    check("m255_pc", o_PC, 32'h400);
    step();
    check_ifid("wrap", 32'h20010005, 32'h404);

    // PC+4 wraps at 2**32
    jump_to(32'hFFFFFFFC);
    step();
    check_ifid("top", 32'hBBBB00FF, 32'h0);
    check("top_pc", o_PC, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
